// File: rtl/comp_job_arbiter_if.sv
// Requester-side and core-side handshake bundle for comp_job_arbiter.
interface comp_job_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int LW        = 9,
  parameter int BEATBYTES = 16
);
  logic [NREQ-1:0]                     req_valid;
  logic [NREQ-1:0][LW-1:0]             req_len;
  logic [NREQ-1:0][BEATBYTES*8-1:0]    req_data;
  logic [NREQ-1:0]                     req_data_valid;
  logic [NREQ-1:0]                     req_data_ready;
  logic [NREQ-1:0]                     grant;
  logic [NREQ-1:0]                     job_done;
  logic [NREQ-1:0]                     job_err;
  logic                                core_start;
  logic [BEATBYTES*8-1:0]              core_byte;
  logic                                core_valid;
  logic                                core_done;
  logic                                core_abort;

  modport master (
    output req_valid, req_len, req_data, req_data_valid, core_done,
    input  req_data_ready, grant, job_done, job_err,
           core_start, core_byte, core_valid, core_abort
  );

  modport slave (
    input  req_valid, req_len, req_data, req_data_valid, core_done,
    output req_data_ready, grant, job_done, job_err,
           core_start, core_byte, core_valid, core_abort
  );
endinterface

// File: rtl/comp_job_arbiter.sv
// Round-robin job arbiter feeding one shared LZRW1 compressor core in 16-byte beats.
// Optional perf counters (perf_jobs, perf_busy) when COMP_JOB_ARBITER_PERF_EN is defined.
module comp_job_arbiter #(
  parameter int NREQ       = 4,
  parameter int STRINGSIZE = 350,
  parameter int BEATBYTES  = 16,
  parameter int TIMEOUT    = 4095,
  parameter int LW         = $clog2(STRINGSIZE + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  comp_job_arbiter_if.slave      bus
`ifdef COMP_JOB_ARBITER_PERF_EN
  ,
  output logic [NREQ-1:0][15:0]  perf_jobs,
  output logic [31:0]            perf_busy
`endif
);
  localparam int IW       = $clog2(NREQ);
  localparam int DW       = BEATBYTES * 8;
  localparam int MAXBEATS = (STRINGSIZE + BEATBYTES - 1) / BEATBYTES;
  localparam int BW       = $clog2(MAXBEATS + 1);
  localparam int TW       = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOAD, S_WAIT, S_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d, g_q, g_d;
  logic [LW-1:0]   len_q, len_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [NREQ-1:0] grant_q, grant_d, done_q, done_d, err_q, err_d;
  logic            start_q, start_d, abort_q, abort_d, cvalid_q, cvalid_d;
  logic [DW-1:0]   cbyte_q, cbyte_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;

  // First pending requester at or above rr_q, wrapping past NREQ-1.
  always_comb begin
    int unsigned idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_q) + i) % 32'(NREQ);
      if (!pick_found && bus.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    g_d      = g_q;
    len_d    = len_q;
    beats_d  = beats_q;
    tmo_d    = tmo_q;
    grant_d  = grant_q;
    cbyte_d  = cbyte_q;
    done_d   = '0;
    err_d    = '0;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    cvalid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          g_d     = pick_idx;
          len_d   = bus.req_len[pick_idx];
          grant_d = NREQ'(1) << pick_idx;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (len_q == '0 || 32'(len_q) > 32'(STRINGSIZE)) begin
          err_d[g_q] = 1'b1;
          state_d    = S_RELEASE;
        end else begin
          start_d = 1'b1;
          beats_d = BW'((32'(len_q) + 32'(BEATBYTES - 1)) / 32'(BEATBYTES));
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.req_data_valid[g_q]) begin
          cbyte_d  = bus.req_data[g_q];
          cvalid_d = 1'b1;
          beats_d  = beats_q - 1'b1;
          if (beats_q == BW'(1)) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // Done takes priority over a timeout landing in the same cycle.
        if (bus.core_done) begin
          done_d[g_q] = 1'b1;
          state_d     = S_RELEASE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d[g_q] = 1'b1;
          abort_d    = 1'b1;
          state_d    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        grant_d = '0;
        rr_d    = (32'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;
        beats_d = '0;
        tmo_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      g_q      <= '0;
      len_q    <= '0;
      beats_q  <= '0;
      tmo_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      cvalid_q <= 1'b0;
      cbyte_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      g_q      <= g_d;
      len_q    <= len_d;
      beats_q  <= beats_d;
      tmo_q    <= tmo_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      cvalid_q <= cvalid_d;
      cbyte_q  <= cbyte_d;
    end
  end

  assign bus.req_data_ready = (state_q == S_LOAD) ? grant_q : '0;
  assign bus.grant          = grant_q;
  assign bus.job_done       = done_q;
  assign bus.job_err        = err_q;
  assign bus.core_start     = start_q;
  assign bus.core_byte      = cbyte_q;
  assign bus.core_valid     = cvalid_q;
  assign bus.core_abort     = abort_q;

`ifdef COMP_JOB_ARBITER_PERF_EN
  logic [NREQ-1:0][15:0] pjobs_q;
  logic [31:0]           pbusy_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pjobs_q <= '0;
      pbusy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (done_q[i] && pjobs_q[i] != '1) pjobs_q[i] <= pjobs_q[i] + 16'd1;
      end
      if (state_q != S_IDLE && pbusy_q != '1) pbusy_q <= pbusy_q + 32'd1;
    end
  end

  assign perf_jobs = pjobs_q;
  assign perf_busy = pbusy_q;
`endif
endmodule

// File: tb/tb_comp_job_arbiter.sv
// Scoreboard bench for comp_job_arbiter: expected output events are queued, a monitor pops and compares.
module tb_comp_job_arbiter;
  localparam int NREQ       = 4;
  localparam int STRINGSIZE = 350;
  localparam int BEATBYTES  = 16;
  localparam int TIMEOUT    = 64;
  localparam int LW         = 9;
  localparam int DW         = 128;

  localparam int K_GRANT = 0, K_START = 1, K_VALID = 2, K_DONE = 3, K_ERR = 4, K_ABORT = 5;

  typedef struct {
    int            kind;
    logic [DW-1:0] val;
    int            gap;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  comp_job_arbiter_if #(.NREQ(NREQ), .LW(LW), .BEATBYTES(BEATBYTES)) bus ();

`ifdef COMP_JOB_ARBITER_PERF_EN
  logic [NREQ-1:0][15:0] perf_jobs;
  logic [31:0]           perf_busy;
`endif

  comp_job_arbiter #(
    .NREQ(NREQ), .STRINGSIZE(STRINGSIZE), .BEATBYTES(BEATBYTES),
    .TIMEOUT(TIMEOUT), .LW(LW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef COMP_JOB_ARBITER_PERF_EN
    ,
    .perf_jobs(perf_jobs),
    .perf_busy(perf_busy)
`endif
  );

  int  checks = 0;
  int  passes = 0;
  ev_t expq[$];
  bit  mon_en = 1'b0;
  int  cyc = 0;
  int  last_ev = 0;
  int  vcount = 0;
  int  onehot_bad = 0;
  logic [NREQ-1:0] prev_grant = '0;

  int       jobs_req[NREQ] = '{default: 0};
  int       jobs_fin[NREQ] = '{default: 0};
  int       beat_idx[NREQ] = '{default: 0};
  int       phase[NREQ]    = '{default: 0};
  logic [3:0] vpat[NREQ]   = '{default: 4'b1111};
  logic [NREQ-1:0] acc;

  function automatic logic [DW-1:0] beat_val(int r, int k);
    return {96'hDEADBEEF0123456789ABCDEF, 16'(r), 16'(k)};
  endfunction

  function automatic string kname(int k);
    case (k)
      K_GRANT: return "GRANT";
      K_START: return "START";
      K_VALID: return "VALID";
      K_DONE:  return "DONE";
      K_ERR:   return "ERR";
      default: return "ABORT";
    endcase
  endfunction

  function automatic void push(int k, logic [DW-1:0] v, int g);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.gap  = g;
    expq.push_back(e);
  endfunction

  function automatic void observe(int k, logic [DW-1:0] v);
    ev_t e;
    int  g;
    g       = cyc - last_ev;
    last_ev = cyc;
    checks++;
    if (expq.size() == 0) begin
      $display("FAIL event: got %s %h at cycle %0d, expected no event", kname(k), v, cyc);
      return;
    end
    e = expq.pop_front();
    if (e.kind == k && e.val === v && (e.gap < 0 || e.gap == g)) passes++;
    else $display("FAIL event: got %s %h after %0d cycles, expected %s %h after %0d cycles",
                  kname(k), v, g, kname(e.kind), e.val, e.gap);
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Monitor: one event per asserted output, fixed in-cycle order.
  initial begin : monitor
    forever begin
      @(negedge clock);
      cyc++;
      if (mon_en) begin
        if ($countones(bus.grant) > 1) onehot_bad++;
        if (bus.grant !== prev_grant) begin
          observe(K_GRANT, DW'(bus.grant));
          prev_grant = bus.grant;
        end
        if (bus.core_start)      observe(K_START, '0);
        if (bus.core_valid) begin
          observe(K_VALID, bus.core_byte);
          vcount++;
        end
        if (bus.job_done != '0)  observe(K_DONE, DW'(bus.job_done));
        if (bus.job_err != '0)   observe(K_ERR, DW'(bus.job_err));
        if (bus.core_abort)      observe(K_ABORT, '0);
      end
    end
  end

  // Requester models: hold req_valid until the job ends, present beats per the valid pattern.
  initial begin : driver
    bus.req_valid      = '0;
    bus.req_data_valid = '0;
    bus.req_data       = '0;
    forever begin
      @(negedge clock);
      for (int r = 0; r < NREQ; r++) begin
        acc[r] = bus.req_data_ready[r] & bus.req_data_valid[r];
        if (mon_en && (bus.job_done[r] || bus.job_err[r])) begin
          jobs_fin[r]++;
          beat_idx[r]      = 0;
          acc[r]           = 1'b0;
          bus.req_valid[r] = (jobs_req[r] > jobs_fin[r]);
        end
      end
      @(posedge clock);
      #1;
      for (int r = 0; r < NREQ; r++) begin
        if (!reset) beat_idx[r] = 0;
        else if (acc[r] === 1'b1) beat_idx[r]++;
        bus.req_valid[r] = (jobs_req[r] > jobs_fin[r]);
        bus.req_data[r]  = beat_val(r, beat_idx[r]);
        if (bus.req_valid[r]) begin
          bus.req_data_valid[r] = vpat[r][phase[r]];
          phase[r] = (phase[r] + 1) % 4;
        end else begin
          bus.req_data_valid[r] = 1'b0;
          phase[r] = 0;
        end
      end
    end
  end

  task automatic sync();
    @(negedge clock);
    #2;
  endtask

  task automatic wait_vcount(int target);
    int n;
    n = 0;
    while (vcount < target && n < 3000) begin
      sync();
      n++;
    end
    check("beat_count", DW'(vcount), DW'(target));
  endtask

  task automatic wait_idle();
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 3000) begin
      sync();
      n++;
      busy = 1'b0;
      for (int r = 0; r < NREQ; r++) if (jobs_fin[r] != jobs_req[r]) busy = 1'b1;
    end
    check("jobs_finished", DW'(busy), DW'(0));
    repeat (2) sync();
  endtask

  // Raise core_done for one cycle, D cycles after the cycle in which the last beat was seen.
  task automatic respond(int d);
    repeat (d) @(posedge clock);
    #1 bus.core_done = 1'b1;
    @(posedge clock);
    #1 bus.core_done = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    int order[5];
    bus.core_done = 1'b0;
    bus.req_len   = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_grant", DW'(bus.grant), '0);
    check("rst_ready", DW'(bus.req_data_ready), '0);
    check("rst_done",  DW'(bus.job_done), '0);
    check("rst_err",   DW'(bus.job_err), '0);
    check("rst_start", DW'(bus.core_start), '0);
    check("rst_valid", DW'(bus.core_valid), '0);
    check("rst_byte",  bus.core_byte, '0);
    check("rst_abort", DW'(bus.core_abort), '0);
    reset  = 1'b1;
    mon_en = 1'b1;
    sync();

    // All four pending, len 32: grants 0,1,2,3,0, two beats each.
    order = '{0, 1, 2, 3, 0};
    for (int r = 0; r < NREQ; r++) bus.req_len[r] = LW'(32);
    for (int j = 0; j < 5; j++) begin
      push(K_GRANT, DW'(4'b0001 << order[j]), (j == 0) ? -1 : 1);
      push(K_START, '0, 1);
      push(K_VALID, beat_val(order[j], 0), 1);
      push(K_VALID, beat_val(order[j], 1), 1);
      push(K_DONE, DW'(4'b0001 << order[j]), 3);
      push(K_GRANT, '0, 1);
    end
    base = vcount;
    jobs_req = '{2, 1, 1, 1};
    for (int j = 0; j < 5; j++) begin
      wait_vcount(base + 2 * (j + 1));
      respond(2);
    end
    wait_idle();

    // Requester 0 alone, full-length job.
    bus.req_len[0] = LW'(350);
    push(K_GRANT, DW'(4'b0001), -1);
    push(K_START, '0, 1);
    for (int k = 0; k < 22; k++) push(K_VALID, beat_val(0, k), 1);
    push(K_DONE, DW'(4'b0001), 6);
    push(K_GRANT, '0, 1);
    base = vcount;
    jobs_req[0]++;
    wait_vcount(base + 22);
    respond(5);
    wait_idle();

    // Requester 2: len 0 then len 351 are both rejected.
    bus.req_len[2] = LW'(0);
    push(K_GRANT, DW'(4'b0100), -1);
    push(K_ERR, DW'(4'b0100), 1);
    push(K_GRANT, '0, 1);
    jobs_req[2]++;
    wait_idle();
    bus.req_len[2] = LW'(351);
    push(K_GRANT, DW'(4'b0100), -1);
    push(K_ERR, DW'(4'b0100), 1);
    push(K_GRANT, '0, 1);
    jobs_req[2]++;
    wait_idle();

    // Requester 1, one beat, core never finishes.
    bus.req_len[1] = LW'(16);
    push(K_GRANT, DW'(4'b0010), -1);
    push(K_START, '0, 1);
    push(K_VALID, beat_val(1, 0), 1);
    push(K_ERR, DW'(4'b0010), TIMEOUT);
    push(K_ABORT, '0, 0);
    push(K_GRANT, '0, 1);
    jobs_req[1]++;
    wait_idle();

    // Pointer now at 2: with 1 and 3 pending, 3 wins first.
    bus.req_len[1] = LW'(0);
    bus.req_len[3] = LW'(0);
    push(K_GRANT, DW'(4'b1000), -1);
    push(K_ERR, DW'(4'b1000), 1);
    push(K_GRANT, '0, 1);
    push(K_GRANT, DW'(4'b0010), 1);
    push(K_ERR, DW'(4'b0010), 1);
    push(K_GRANT, '0, 1);
    jobs_req[1]++;
    jobs_req[3]++;
    wait_idle();

    // Requester 3, len 48 with bubbles; a stray core_done during LOAD.
    bus.req_len[3] = LW'(48);
    vpat[3] = 4'b1001;
    push(K_GRANT, DW'(4'b1000), -1);
    push(K_START, '0, 1);
    push(K_VALID, beat_val(3, 0), 2);
    push(K_VALID, beat_val(3, 1), 1);
    push(K_VALID, beat_val(3, 2), 3);
    push(K_DONE, DW'(4'b1000), 4);
    push(K_GRANT, '0, 1);
    base = vcount;
    jobs_req[3]++;
    wait_vcount(base + 1);
    @(posedge clock);
    #1 bus.core_done = 1'b1;
    @(posedge clock);
    #1 bus.core_done = 1'b0;
    wait_vcount(base + 3);
    respond(3);
    wait_idle();

    // Reset during LOAD after ten beats; the job restarts from beat 0.
    bus.req_len[0] = LW'(350);
    push(K_GRANT, DW'(4'b0001), -1);
    push(K_START, '0, 1);
    for (int k = 0; k < 10; k++) push(K_VALID, beat_val(0, k), 1);
    push(K_GRANT, '0, 1);
    base = vcount;
    jobs_req[0]++;
    wait_vcount(base + 10);
    reset = 1'b0;
    push(K_GRANT, DW'(4'b0001), 1);
    push(K_START, '0, 1);
    for (int k = 0; k < 22; k++) push(K_VALID, beat_val(0, k), 1);
    push(K_DONE, DW'(4'b0001), 6);
    push(K_GRANT, '0, 1);
    sync();
    check("mid_rst_grant", DW'(bus.grant), '0);
    check("mid_rst_ready", DW'(bus.req_data_ready), '0);
    check("mid_rst_valid", DW'(bus.core_valid), '0);
    check("mid_rst_byte",  bus.core_byte, '0);
    check("mid_rst_start", DW'(bus.core_start), '0);
    reset = 1'b1;
    wait_vcount(base + 10 + 22);
    respond(5);
    wait_idle();

    repeat (4) sync();
    check("queue_empty", DW'(expq.size()), '0);
    check("grant_onehot", DW'(onehot_bad), '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
